// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel enable, h/v counters, sync windows and a
// registered colour output stage. Optional colour bars behind VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int DIV      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int CW       = 11
) (
  input  logic                   clk_100m,
  input  logic                   rst,
  output logic                   pix_en,
  output logic                   req,
  output logic [CW-1:0]          x,
  output logic [CW-1:0]          y,
  input  logic [R_W+G_W+B_W-1:0] rgb_in,
  input  logic                   test_en,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [R_W-1:0]         vga_r,
  output logic [G_W-1:0]         vga_g,
  output logic [B_W-1:0]         vga_b,
  output logic                   frame_start
);

  localparam int PW      = R_W + G_W + B_W;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  logic [CW-1:0] h_cnt, v_cnt;
  logic          hs_win, vs_win;
  logic [PW-1:0] col_src;

  if (DIV == 1) begin : g_nodiv
    assign pix_en = 1'b1;
  end else begin : g_div
    localparam int DW = $clog2(DIV);
    localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk_100m) begin
      if (rst)                    div_cnt <= '0;
      else if (div_cnt == D_LAST) div_cnt <= '0;
      else                        div_cnt <= div_cnt + DW'(1);
    end

    assign pix_en = (div_cnt == D_LAST);
  end

  always_ff @(posedge clk_100m) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  assign x      = h_cnt;
  assign y      = v_cnt;
  assign req    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_win = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_win = (v_cnt >= V_SS) && (v_cnt < V_SE);

`ifdef VGA_TEST_PATTERN_EN
  // Bar width floors at one pixel so tiny test rasters still divide cleanly.
  localparam int BAR_W = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  logic [CW-1:0] bar_q;
  logic [2:0]    bar;

  assign bar_q   = h_cnt / CW'(BAR_W);
  assign bar     = (bar_q > CW'(7)) ? 3'd7 : bar_q[2:0];
  assign col_src = test_en ? {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}} : rgb_in;
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
  assign col_src        = rgb_in;
`endif

  // Output stage captures the coordinate that is ending on this tick, so
  // everything here lags x/y by exactly one pixel period.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        de    <= req;
        hsync <= hs_win ? HS_POL : ~HS_POL;
        vsync <= vs_win ? VS_POL : ~VS_POL;
        vga_r <= req ? col_src[PW-1 -: R_W]      : '0;
        vga_g <= req ? col_src[G_W+B_W-1 -: G_W] : '0;
        vga_b <= req ? col_src[B_W-1:0]          : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default raster at DIV=4 and a tiny DIV=1 raster with positive syncs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, te_a, te_b;
  logic [7:0]  rgb_a, rgb_b;
  logic        pe_a, req_a, hs_a, vs_a, de_a, fs_a;
  logic        pe_b, req_b, hs_b, vs_b, de_b, fs_b;
  logic [10:0] x_a, y_a, x_b, y_b;
  logic [2:0]  r_a, g_a, r_b, g_b;
  logic [1:0]  b_a, b_b;

  vga_timing_gen #(.DIV(4)) u_a (
    .clk_100m(clk), .rst(rst_a), .pix_en(pe_a), .req(req_a), .x(x_a), .y(y_a),
    .rgb_in(rgb_a), .test_en(te_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_b (
    .clk_100m(clk), .rst(rst_b), .pix_en(pe_b), .req(req_b), .x(x_b), .y(y_b),
    .rgb_in(rgb_b), .test_en(te_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
  );

  int n_chk = 0, n_fail = 0;
  int e_pix, e_xy, e_de, e_hs, e_vs, e_col, e_fs;
  int hs_fall1, hs_fall2, hs_rise1, hs_rise2, de_cnt, vs_cnt, fs_cnt, fs_first, fs_second;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] col_model(input int hm, input int hact, input logic te,
                                           input logic [7:0] rgb);
    logic [7:0] c;
    int         bi;
    logic [2:0] bb;
    c  = rgb;
    bi = 0;
    bb = 3'd0;
    if (te) begin
`ifdef VGA_TEST_PATTERN_EN
      bi = hm / (hact / 8);
      if (bi > 7) bi = 7;
      bb = bi[2:0];
      c  = {{3{bb[2]}}, {3{bb[1]}}, {2{bb[0]}}};
`endif
    end
    return c;
  endfunction

  task automatic clr_stats();
    e_pix = 0; e_xy = 0; e_de = 0; e_hs = 0; e_vs = 0; e_col = 0; e_fs = 0;
    hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1; hs_rise2 = -1;
    de_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
  endtask

  // Default raster, DIV=4. Called at a negedge right after reset release.
  task automatic run_a(input int ncyc);
    int ca, n, hm, vm;
    logic tick, exp_de, exp_hs, exp_vs, exp_fs, prev_hs;
    logic [7:0] exp_c, drv;
    clr_stats();
    ca = 0; exp_de = 0; exp_hs = 1; exp_vs = 1; exp_c = 0; prev_hs = 1;
    for (int i = 0; i < ncyc; i++) begin
      n = ca / 4; hm = n % 800; vm = (n / 800) % 525;
      te_a = (ca >= 3200);
      drv = hm[7:0];
      if (te_a) drv = ~drv;
      rgb_a = drv;
      tick = (ca % 4 == 3);
      exp_fs = 0;
      if (tick) begin
        exp_de = (hm < 640) && (vm < 480);
        exp_hs = !((hm >= 656) && (hm < 752));
        exp_vs = !((vm >= 490) && (vm < 492));
        exp_c  = exp_de ? col_model(hm, 640, te_a, drv) : 8'd0;
        exp_fs = (hm == 0) && (vm == 0);
      end
      @(posedge clk); ca++; @(negedge clk);
      n = ca / 4;
      if (pe_a !== (ca % 4 == 3)) e_pix++;
      if (x_a !== 11'(n % 800) || y_a !== 11'((n / 800) % 525)) e_xy++;
      if (de_a !== exp_de) e_de++;
      if (hs_a !== exp_hs) e_hs++;
      if (vs_a !== exp_vs) e_vs++;
      if ({r_a, g_a, b_a} !== exp_c) e_col++;
      if (fs_a !== exp_fs) e_fs++;
      if (prev_hs && !hs_a) begin
        if (hs_fall1 < 0) hs_fall1 = ca;
        else if (hs_fall2 < 0) hs_fall2 = ca;
      end
      if (!prev_hs && hs_a && hs_rise1 < 0) hs_rise1 = ca;
      prev_hs = hs_a;
      if (de_a && ca < 3200) de_cnt++;
      if (fs_a) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = ca;
      end
    end
  endtask

  // Small raster, DIV=1, 12x7 totals, random colour and test_en every clock.
  task automatic run_b(input int ncyc);
    int cb, hm, vm;
    logic exp_de, exp_hs, exp_vs, exp_fs, prev_hs;
    logic [7:0] exp_c, drv;
    clr_stats();
    cb = 0; prev_hs = 0;
    for (int i = 0; i < ncyc; i++) begin
      hm = cb % 12; vm = (cb / 12) % 7;
      te_b = 1'($urandom_range(0, 1));
      drv  = 8'($urandom_range(0, 255));
      rgb_b = drv;
      exp_de = (hm < 8) && (vm < 4);
      exp_hs = (hm >= 9) && (hm < 11);
      exp_vs = (vm == 5);
      exp_c  = exp_de ? col_model(hm, 8, te_b, drv) : 8'd0;
      exp_fs = (hm == 0) && (vm == 0);
      @(posedge clk); cb++; @(negedge clk);
      if (pe_b !== 1'b1) e_pix++;
      if (x_b !== 11'(cb % 12) || y_b !== 11'((cb / 12) % 7)) e_xy++;
      if (de_b !== exp_de) e_de++;
      if (hs_b !== exp_hs) e_hs++;
      if (vs_b !== exp_vs) e_vs++;
      if ({r_b, g_b, b_b} !== exp_c) e_col++;
      if (fs_b !== exp_fs) e_fs++;
      if (!prev_hs && hs_b) begin
        if (hs_rise1 < 0) hs_rise1 = cb;
        else if (hs_rise2 < 0) hs_rise2 = cb;
      end
      if (prev_hs && !hs_b && hs_fall1 < 0) hs_fall1 = cb;
      prev_hs = hs_b;
      if (cb <= 84 && de_b) de_cnt++;
      if (cb <= 84 && vs_b) vs_cnt++;
      if (fs_b) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = cb;
        else if (fs_second < 0) fs_second = cb;
      end
    end
  endtask

  initial begin
    rst_a = 1; rst_b = 1; te_a = 0; te_b = 0; rgb_a = 0; rgb_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_rst_xy",   {x_a, y_a}, 0);
    chk("a_rst_req",  req_a, 1);
    chk("a_rst_pe",   pe_a, 0);
    chk("a_rst_sync", {hs_a, vs_a}, 2'b11);
    chk("a_rst_de",   de_a, 0);
    chk("a_rst_col",  {r_a, g_a, b_a}, 0);
    chk("a_rst_fs",   fs_a, 0);
    chk("b_rst_pe",   pe_b, 1);
    chk("b_rst_sync", {hs_b, vs_b}, 2'b00);
    chk("b_rst_de",   de_b, 0);

    rst_a = 0;
    run_a(9202);
    chk("a_pix_en",    e_pix, 0);
    chk("a_xy",        e_xy, 0);
    chk("a_de",        e_de, 0);
    chk("a_hsync",     e_hs, 0);
    chk("a_vsync",     e_vs, 0);
    chk("a_colour",    e_col, 0);
    chk("a_fs",        e_fs, 0);
    chk("a_hs_fall",   hs_fall1, 2628);
    chk("a_hs_width",  hs_rise1 - hs_fall1, 384);
    chk("a_line",      hs_fall2 - hs_fall1, 3200);
    chk("a_de_clocks", de_cnt, 2560);
    chk("a_fs_first",  fs_first, 4);
    chk("a_fs_count",  fs_cnt, 1);
    chk("a_pre_rst_x", x_a, 700);
    chk("a_pre_rst_hs", hs_a, 0);

    rst_a = 1;
    @(posedge clk); @(negedge clk);
    chk("a_mid_rst_xy",   {x_a, y_a}, 0);
    chk("a_mid_rst_sync", {hs_a, vs_a}, 2'b11);
    chk("a_mid_rst_de",   de_a, 0);
    chk("a_mid_rst_col",  {r_a, g_a, b_a}, 0);
    chk("a_mid_rst_pe",   pe_a, 0);
    @(posedge clk); @(negedge clk);
    rst_a = 0;
    run_a(24);
    chk("a_resume_xy",  e_xy, 0);
    chk("a_resume_out", e_de + e_hs + e_vs + e_col, 0);
    chk("a_resume_fs",  fs_first, 4);

    rst_b = 0;
    run_b(180);
    chk("b_pix_en",     e_pix, 0);
    chk("b_xy",         e_xy, 0);
    chk("b_de",         e_de, 0);
    chk("b_hsync",      e_hs, 0);
    chk("b_vsync",      e_vs, 0);
    chk("b_colour",     e_col, 0);
    chk("b_fs",         e_fs, 0);
    chk("b_hs_rise",    hs_rise1, 10);
    chk("b_hs_width",   hs_fall1 - hs_rise1, 2);
    chk("b_line",       hs_rise2 - hs_rise1, 12);
    chk("b_fs_first",   fs_first, 1);
    chk("b_frame",      fs_second - fs_first, 84);
    chk("b_fs_count",   fs_cnt, 3);
    chk("b_de_clocks",  de_cnt, 32);
    chk("b_vs_clocks",  vs_cnt, 12);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
